// File: rtl/sf_term_line_streamer.sv
// Serializes one terminal status line (MSB byte first) into a valid/ready byte stream.
// Optional build macro SF_LINE_CHANGE_ONLY_EN: timer-only refreshes are skipped when the line is unchanged.
module sf_term_line_streamer #(
    parameter int parm_line_len       = 35,
    parameter int parm_refresh_cycles = 4_000_000
) (
    input  logic                       i_clk_40mhz,
    input  logic                       i_rstn_40mhz,
    input  logic [parm_line_len*8-1:0] i_term_ascii_line,
    input  logic                       i_send_req,
    output logic [7:0]                 o_tx_data,
    output logic                       o_tx_valid,
    input  logic                       i_tx_ready,
    output logic                       o_busy,
    output logic                       o_line_done
);

    localparam int LW = parm_line_len * 8;
    localparam int CW = (parm_line_len > 1) ? $clog2(parm_line_len) : 1;
    localparam int TW = $clog2(parm_refresh_cycles);
    localparam logic [CW-1:0] CNT_LAST   = CW'(parm_line_len - 1);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(parm_refresh_cycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [LW-1:0]   snap_q, snap_d;
    logic            pend_q, pend_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, busy_q, done_q;
    logic            expire, trigger, accept, start;

    assign expire  = (timer_q == '0);
    assign timer_d = expire ? TMR_RELOAD : timer_q - TW'(1);
    assign trigger = i_send_req | expire;
    assign accept  = tx_valid_q & i_tx_ready;

`ifdef SF_LINE_CHANGE_ONLY_EN
    logic [LW-1:0] last_q;
    logic          pend_req_q;
    logic          changed;

    // Requests (direct or pending) always send; timer events only when the line differs.
    assign changed = (i_term_ascii_line != last_q);
    assign start   = i_send_req | (pend_q & pend_req_q) | ((expire | pend_q) & changed);

    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            last_q     <= '0;
            pend_req_q <= 1'b0;
        end else begin
            if (state_q == ST_DONE) begin
                last_q <= snap_q;
            end
            if (state_q == ST_IDLE) begin
                pend_req_q <= 1'b0;
            end else if (i_send_req) begin
                pend_req_q <= 1'b1;
            end
        end
    end
`else
    assign start = trigger | pend_q;
`endif

    // One-deep pending: cleared whenever IDLE consumes it.
    always_comb begin
        pend_d = pend_q;
        if (state_q == ST_IDLE) begin
            pend_d = 1'b0;
        end else if (trigger) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                snap_d  = i_term_ascii_line;
                cnt_d   = CNT_LAST;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (accept) begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from next-state so they line up with the state register.
        if (state_d == ST_SEND) begin
            tx_data_d = snap_d[cnt_d*8 +: 8];
        end
    end

    always_ff @(posedge i_clk_40mhz or negedge i_rstn_40mhz) begin
        if (!i_rstn_40mhz) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            timer_q    <= TMR_RELOAD;
            snap_q     <= '0;
            pend_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            snap_q     <= snap_d;
            pend_q     <= pend_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= (state_d == ST_SEND);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_valid  = tx_valid_q;
    assign o_busy      = busy_q;
    assign o_line_done = done_q;

endmodule

// File: tb/tb_sf_term_line_streamer.sv
// Directed bench for sf_term_line_streamer: instance A (slow timer) for request traffic,
// instance B (100-cycle refresh) for timer behaviour.
module tb_sf_term_line_streamer;

    localparam int LEN = 35;
    localparam int LW  = LEN * 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [LW-1:0] line_a, line_b, line_b_eff;
    logic          req_a = 1'b0, req_b = 1'b0, rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0]    data_a, data_b;
    logic          vld_a, vld_b, busy_a, busy_b, done_a, done_b;
    logic          b_vary = 1'b1;
    int            cyc = 0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_bytes [LEN];

    // While b_vary is set, B's line changes every cycle (top bit set so it never equals ASCII).
    assign line_b_eff = b_vary ? {line_b[LW-1:8], 1'b1, cyc[6:0]} : line_b;

    sf_term_line_streamer #(.parm_line_len(LEN), .parm_refresh_cycles(1_000_000)) dut_a (
        .i_clk_40mhz      (clk),
        .i_rstn_40mhz     (rst_n),
        .i_term_ascii_line(line_a),
        .i_send_req       (req_a),
        .o_tx_data        (data_a),
        .o_tx_valid       (vld_a),
        .i_tx_ready       (rdy_a),
        .o_busy           (busy_a),
        .o_line_done      (done_a)
    );

    sf_term_line_streamer #(.parm_line_len(LEN), .parm_refresh_cycles(100)) dut_b (
        .i_clk_40mhz      (clk),
        .i_rstn_40mhz     (rst_n),
        .i_term_ascii_line(line_b_eff),
        .i_send_req       (req_b),
        .o_tx_data        (data_b),
        .o_tx_valid       (vld_b),
        .i_tx_ready       (rdy_b),
        .o_busy           (busy_b),
        .o_line_done      (done_b)
    );

    logic [7:0] a_rx [$];
    int         b_starts [$];
    int         a_dones = 0, a_stab_err = 0;
    logic       a_stall_q = 1'b0, b_vld_q = 1'b0;
    logic [7:0] a_data_q = 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (vld_a && rdy_a) a_rx.push_back(data_a);
            if (done_a) a_dones <= a_dones + 1;
            if (a_stall_q && (!vld_a || data_a !== a_data_q)) a_stab_err <= a_stab_err + 1;
            if (vld_b && !b_vld_q) b_starts.push_back(cyc);
        end
        a_stall_q <= rst_n && vld_a && !rdy_a;
        a_data_q  <= data_a;
        b_vld_q   <= vld_b;
    end

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (vld_a !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", vld_a); end
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_a); end
        checks++; if (busy_a !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        checks++; if (done_a !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done_a); end
        checks++; if (vld_b !== 1'b0)   begin failures++; $display("FAIL reset_valid_b got=%b exp=0", vld_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_line();
        int base, d0, done_n, idle_n;
        base = a_rx.size(); d0 = a_dones; done_n = -1; idle_n = -1;
        rdy_a = 1'b1;
        req_a = 1'b1;
        @(negedge clk); req_a = 1'b0;
        checks++; if (vld_a !== 1'b0) begin failures++; $display("FAIL load_valid got=%b exp=0", vld_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", busy_a); end
        @(negedge clk);
        checks++; if (vld_a !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", vld_a); end
        checks++; if (data_a !== 8'h53) begin failures++; $display("FAIL first_byte got=%h exp=53", data_a); end
        for (int n = 3; n <= 80 && idle_n < 0; n++) begin
            @(negedge clk);
            if (done_a && done_n < 0) done_n = n;
            if (!busy_a) idle_n = n;
        end
        checks++; if (done_n != 37) begin failures++; $display("FAIL done_cycle got=%0d exp=37", done_n); end
        checks++; if (idle_n != 38) begin failures++; $display("FAIL idle_cycle got=%0d exp=38", idle_n); end
        checks++; if (a_dones - d0 != 1) begin failures++; $display("FAIL single_dones got=%0d exp=1", a_dones - d0); end
        checks++; if (a_rx.size() - base != LEN) begin failures++; $display("FAIL single_count got=%0d exp=%0d", a_rx.size() - base, LEN); end
        for (int i = 0; i < LEN && base + i < a_rx.size(); i++) begin
            checks++;
            if (a_rx[base+i] !== exp_bytes[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, a_rx[base+i], exp_bytes[i]); end
        end
    endtask

    task automatic test_stall();
        int base, d0, s0;
        base = a_rx.size(); d0 = a_dones; s0 = a_stab_err;
        rdy_a = 1'b0;
        req_a = 1'b1;
        @(negedge clk); req_a = 1'b0;
        for (int k = 0; k < 400 && a_dones == d0; k++) begin
            @(negedge clk);
            rdy_a = (k % 3 == 2);
            if (a_rx.size() - base == 5) line_a = {LEN{8'h5A}};
        end
        rdy_a = 1'b1;
        checks++; if (a_dones - d0 != 1) begin failures++; $display("FAIL stall_dones got=%0d exp=1", a_dones - d0); end
        checks++; if (a_rx.size() - base != LEN) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", a_rx.size() - base, LEN); end
        checks++; if (a_stab_err != s0) begin failures++; $display("FAIL stall_stable got=%0d exp=%0d", a_stab_err, s0); end
        for (int i = 0; i < LEN && base + i < a_rx.size(); i++) begin
            checks++;
            if (a_rx[base+i] !== exp_bytes[i]) begin failures++; $display("FAIL stall_byte%0d got=%h exp=%h", i, a_rx[base+i], exp_bytes[i]); end
        end
        line_a = {"SF3 PA h00000000 GO  ERR 00000000", 8'h0D, 8'h0A};
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int base, d0;
        base = a_rx.size(); d0 = a_dones;
        rdy_a = 1'b1;
        req_a = 1'b1;
        for (int k = 0; k < 300 && a_dones - d0 < 2; k++) begin
            @(negedge clk);
            req_a = (k == 10 || k == 20);
        end
        req_a = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (a_dones - d0 != 2) begin failures++; $display("FAIL b2b_dones got=%0d exp=2", a_dones - d0); end
        checks++; if (a_rx.size() - base != 2 * LEN) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", a_rx.size() - base, 2 * LEN); end
        for (int i = 0; i < LEN && base + LEN + i < a_rx.size(); i++) begin
            checks++;
            if (a_rx[base+LEN+i] !== exp_bytes[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, a_rx[base+LEN+i], exp_bytes[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int base, d0;
        base = a_rx.size(); d0 = a_dones;
        rdy_a = 1'b1;
        req_a = 1'b1;
        @(negedge clk); req_a = 1'b0;
        for (int k = 0; k < 60 && a_rx.size() - base < 10; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (vld_a !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", vld_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (a_dones != d0) begin failures++; $display("FAIL abort_nodone got=%0d exp=%0d", a_dones, d0); end
        checks++; if (a_rx.size() - base != 10) begin failures++; $display("FAIL abort_count got=%0d exp=10", a_rx.size() - base); end
        base = a_rx.size(); d0 = a_dones;
        req_a = 1'b1;
        @(negedge clk); req_a = 1'b0;
        for (int k = 0; k < 80 && a_dones == d0; k++) @(negedge clk);
        checks++; if (a_rx.size() - base != LEN) begin failures++; $display("FAIL after_abort_count got=%0d exp=%0d", a_rx.size() - base, LEN); end
        for (int i = 0; i < LEN && base + i < a_rx.size(); i++) begin
            checks++;
            if (a_rx[base+i] !== exp_bytes[i]) begin failures++; $display("FAIL after_abort_byte%0d got=%h exp=%h", i, a_rx[base+i], exp_bytes[i]); end
        end
    endtask

    task automatic test_timer();
        int base, s, later, first_later;
        base = b_starts.size();
        for (int k = 0; k < 400 && b_starts.size() < base + 3; k++) @(negedge clk);
        checks++; if (b_starts.size() < base + 3) begin failures++; $display("FAIL timer_starts got=%0d exp>=3", b_starts.size() - base); end
        if (b_starts.size() >= base + 3) begin
            checks++; if (b_starts[base+1] - b_starts[base] != 100) begin failures++; $display("FAIL timer_period1 got=%0d exp=100", b_starts[base+1] - b_starts[base]); end
            checks++; if (b_starts[base+2] - b_starts[base+1] != 100) begin failures++; $display("FAIL timer_period2 got=%0d exp=100", b_starts[base+2] - b_starts[base+1]); end
        end
        s = b_starts[b_starts.size()-1];
        // Next expiry edge is 98 cycles after the observed start; hold the request across it.
        for (int k = 0; k < 200 && cyc < s + 98; k++) @(negedge clk);
        req_b = 1'b1;
        @(negedge clk); req_b = 1'b0;
        for (int k = 0; k < 200 && cyc < s + 195; k++) @(negedge clk);
        later = 0; first_later = -1;
        foreach (b_starts[i]) begin
            if (b_starts[i] > s) begin
                later++;
                if (first_later < 0) first_later = b_starts[i];
            end
        end
        checks++; if (later != 1) begin failures++; $display("FAIL coincide_lines got=%0d exp=1", later); end
        checks++; if (first_later != s + 100) begin failures++; $display("FAIL coincide_start got=%0d exp=%0d", first_later, s + 100); end
    endtask

`ifdef SF_LINE_CHANGE_ONLY_EN
    task automatic test_change_only();
        int base;
        b_vary = 1'b0;
        base = b_starts.size();
        for (int k = 0; k < 120 && b_starts.size() < base + 1; k++) @(negedge clk);
        checks++; if (b_starts.size() != base + 1) begin failures++; $display("FAIL chg_first got=%0d exp=1", b_starts.size() - base); end
        repeat (210) @(negedge clk);
        checks++; if (b_starts.size() != base + 1) begin failures++; $display("FAIL chg_silent got=%0d exp=1", b_starts.size() - base); end
        line_b[15:8] = line_b[15:8] ^ 8'h01;
        repeat (120) @(negedge clk);
        checks++; if (b_starts.size() != base + 2) begin failures++; $display("FAIL chg_altered got=%0d exp=2", b_starts.size() - base); end
        repeat (45) @(negedge clk);
        req_b = 1'b1;
        @(negedge clk); req_b = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (b_starts.size() != base + 3) begin failures++; $display("FAIL chg_request got=%0d exp=3", b_starts.size() - base); end
    endtask
`endif

    initial begin
        string s;
        s = "SF3 PA h00000000 GO  ERR 00000000";
        for (int i = 0; i < 33; i++) exp_bytes[i] = s[i];
        exp_bytes[33] = 8'h0D;
        exp_bytes[34] = 8'h0A;
        line_a = {"SF3 PA h00000000 GO  ERR 00000000", 8'h0D, 8'h0A};
        line_b = line_a;

        test_reset();
        test_single_line();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_timer();
`ifdef SF_LINE_CHANGE_ONLY_EN
        test_change_only();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
